// File: rtl/sprite_mapper.sv
`default_nettype none
// ============================================================================
// Module      : sprite_mapper
// Description : Multi-sprite pixel colouriser for the VGA path. Holds
//               NUM_SPRITES glyph sprites taken from the font ROM. Sprite
//               attributes are double-buffered: writes go to a shadow bank,
//               which is copied to the active bank on frame_start. During
//               hblank a small FSM prefetches one ROM row per sprite into
//               line registers. During active video a registered,
//               priority-resolved RGB value is produced for each DrawX.
// Ports       : Clk, Reset_n            - pixel clock, async active-low reset
//               frame_start             - shadow -> active copy strobe
//               wr_*                    - shadow register write port
//               line_start, line_y      - start a row prefetch for line_y
//               rom_addr, rom_data      - synchronous font ROM interface
//               pixel_valid, DrawX      - current pixel
//               Red/Green/Blue, hit,
//               hit_idx                 - registered pixel result
//               fetch_busy              - prefetch in progress
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_mapper #(
    parameter int          NUM_SPRITES = 4,
    parameter int          COORD_W     = 10,
    parameter logic [23:0] BG_COLOR    = 24'hFFFFFF,
    localparam int         IDX_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_start,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic [6:0]         wr_glyph,
    input  logic [23:0]        wr_color,
    input  logic               wr_scale,
    input  logic               wr_enable,
    input  logic               line_start,
    input  logic [COORD_W-1:0] line_y,
    output logic [10:0]        rom_addr,
    input  logic [7:0]         rom_data,
    input  logic               pixel_valid,
    input  logic [COORD_W-1:0] DrawX,
    output logic [7:0]         Red,
    output logic [7:0]         Green,
    output logic [7:0]         Blue,
    output logic               hit,
    output logic [IDX_W-1:0]   hit_idx,
    output logic               fetch_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Shadow and active attribute banks
    logic [COORD_W-1:0] r_sh_x     [NUM_SPRITES];
    logic [COORD_W-1:0] r_sh_y     [NUM_SPRITES];
    logic [6:0]         r_sh_glyph [NUM_SPRITES];
    logic [23:0]        r_sh_color [NUM_SPRITES];
    logic               r_sh_scale [NUM_SPRITES];
    logic               r_sh_en    [NUM_SPRITES];
    logic [COORD_W-1:0] r_act_x     [NUM_SPRITES];
    logic [COORD_W-1:0] r_act_y     [NUM_SPRITES];
    logic [6:0]         r_act_glyph [NUM_SPRITES];
    logic [23:0]        r_act_color [NUM_SPRITES];
    logic               r_act_scale [NUM_SPRITES];
    logic               r_act_en    [NUM_SPRITES];
    logic [7:0]         r_row       [NUM_SPRITES];

    logic [NUM_SPRITES-1:0] w_sel;

    always_comb begin
        for (int k = 0; k < NUM_SPRITES; k++) begin
            w_sel[k] = wr_en && (wr_idx == IDX_W'(k));
        end
    end

    // A write coinciding with frame_start is forwarded straight into the
    // active bank so the freshly written value is the one that goes live.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int k = 0; k < NUM_SPRITES; k++) begin
                r_sh_x[k]      <= '0;
                r_sh_y[k]      <= '0;
                r_sh_glyph[k]  <= '0;
                r_sh_color[k]  <= '0;
                r_sh_scale[k]  <= 1'b0;
                r_sh_en[k]     <= 1'b0;
                r_act_x[k]     <= '0;
                r_act_y[k]     <= '0;
                r_act_glyph[k] <= '0;
                r_act_color[k] <= '0;
                r_act_scale[k] <= 1'b0;
                r_act_en[k]    <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NUM_SPRITES; k++) begin
                if (w_sel[k]) begin
                    r_sh_x[k]     <= wr_x;
                    r_sh_y[k]     <= wr_y;
                    r_sh_glyph[k] <= wr_glyph;
                    r_sh_color[k] <= wr_color;
                    r_sh_scale[k] <= wr_scale;
                    r_sh_en[k]    <= wr_enable;
                end
                if (frame_start) begin
                    r_act_x[k]     <= w_sel[k] ? wr_x      : r_sh_x[k];
                    r_act_y[k]     <= w_sel[k] ? wr_y      : r_sh_y[k];
                    r_act_glyph[k] <= w_sel[k] ? wr_glyph  : r_sh_glyph[k];
                    r_act_color[k] <= w_sel[k] ? wr_color  : r_sh_color[k];
                    r_act_scale[k] <= w_sel[k] ? wr_scale  : r_sh_scale[k];
                    r_act_en[k]    <= w_sel[k] ? wr_enable : r_sh_en[k];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Row prefetch
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [IDX_W-1:0]   r_issue_idx;
    logic [COORD_W-1:0] r_line_y;
    logic               r_cap_valid;
    logic [IDX_W-1:0]   r_cap_idx;
    logic               r_cap_zero;

    logic [COORD_W:0]   w_dy;
    logic [3:0]         w_row_sel;
    logic               w_on_line;

    // Vertical test for the slot being issued; the extra MSB of w_dy is
    // the sign, so lines above the sprite are rejected.
    always_comb begin
        w_dy      = {1'b0, r_line_y} - {1'b0, r_act_y[r_issue_idx]};
        w_row_sel = r_act_scale[r_issue_idx] ? w_dy[4:1] : w_dy[3:0];
        w_on_line = r_act_en[r_issue_idx] && !w_dy[COORD_W] &&
                    (r_act_scale[r_issue_idx] ? (w_dy[COORD_W-1:5] == '0)
                                              : (w_dy[COORD_W-1:4] == '0));
        rom_addr  = (r_state == S_ISSUE) ? {r_act_glyph[r_issue_idx], w_row_sel} : 11'd0;
    end

    assign fetch_busy = (r_state != S_IDLE);

    // line_start in any state (re)starts the sweep from slot 0.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= S_IDLE;
            r_issue_idx <= '0;
            r_line_y    <= '0;
            r_cap_valid <= 1'b0;
            r_cap_idx   <= '0;
            r_cap_zero  <= 1'b0;
        end else begin
            r_cap_valid <= (r_state == S_ISSUE);
            r_cap_idx   <= r_issue_idx;
            r_cap_zero  <= !w_on_line;
            if (line_start) begin
                r_state     <= S_ISSUE;
                r_issue_idx <= '0;
                r_line_y    <= line_y;
            end else begin
                case (r_state)
                    S_ISSUE: begin
                        if (r_issue_idx == IDX_W'(NUM_SPRITES - 1)) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_issue_idx <= r_issue_idx + 1'b1;
                        end
                    end
                    S_DRAIN: r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // ROM data arrives one cycle after issue; off-line slots store zero.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int k = 0; k < NUM_SPRITES; k++) begin
                r_row[k] <= 8'h00;
            end
        end else if (r_cap_valid) begin
            r_row[r_cap_idx] <= r_cap_zero ? 8'h00 : rom_data;
        end
    end

    // ------------------------------------------------------------------
    // Pixel evaluation
    // ------------------------------------------------------------------
    logic [COORD_W:0]       w_dx  [NUM_SPRITES];
    logic [2:0]             w_col [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] w_cov;
    logic                   w_any;
    logic [IDX_W-1:0]       w_win;

    // Unsigned-with-sign-bit subtraction means pixels left of the sprite
    // (including a would-be wrap past 2^COORD_W) are never covered.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = 0; k < NUM_SPRITES; k++) begin
            w_dx[k]  = {1'b0, DrawX} - {1'b0, r_act_x[k]};
            w_col[k] = r_act_scale[k] ? w_dx[k][3:1] : w_dx[k][2:0];
            w_cov[k] = r_act_en[k] && !w_dx[k][COORD_W] &&
                       (r_act_scale[k] ? (w_dx[k][COORD_W-1:4] == '0)
                                       : (w_dx[k][COORD_W-1:3] == '0)) &&
                       r_row[k][3'd7 - w_col[k]];
        end
        // Scan downwards so the lowest covering index is the last one kept.
        for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
            if (w_cov[k]) begin
                w_any = 1'b1;
                w_win = IDX_W'(k);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            {Red, Green, Blue} <= 24'h000000;
            hit                <= 1'b0;
            hit_idx            <= '0;
        end else if (pixel_valid && w_any) begin
            {Red, Green, Blue} <= r_act_color[w_win];
            hit                <= 1'b1;
            hit_idx            <= w_win;
        end else if (pixel_valid) begin
            {Red, Green, Blue} <= BG_COLOR;
            hit                <= 1'b0;
            hit_idx            <= '0;
        end else begin
            {Red, Green, Blue} <= 24'h000000;
            hit                <= 1'b0;
            hit_idx            <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_mapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_mapper
// Description : Directed self-checking bench for sprite_mapper with a
//               behavioural synchronous font ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_mapper;

    localparam int N = 4;

    int n_cmp = 0;
    int n_err = 0;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_idx = '0;
    logic [9:0]  wr_x = '0;
    logic [9:0]  wr_y = '0;
    logic [6:0]  wr_glyph = '0;
    logic [23:0] wr_color = '0;
    logic        wr_scale = 1'b0;
    logic        wr_enable = 1'b0;
    logic        line_start = 1'b0;
    logic [9:0]  line_y = '0;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic        pixel_valid = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [7:0]  Red, Green, Blue;
    logic        hit;
    logic [1:0]  hit_idx;
    logic        fetch_busy;

    sprite_mapper #(.NUM_SPRITES(N), .COORD_W(10), .BG_COLOR(24'hFFFFFF)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
        .wr_glyph(wr_glyph), .wr_color(wr_color), .wr_scale(wr_scale),
        .wr_enable(wr_enable), .line_start(line_start), .line_y(line_y),
        .rom_addr(rom_addr), .rom_data(rom_data), .pixel_valid(pixel_valid),
        .DrawX(DrawX), .Red(Red), .Green(Green), .Blue(Blue), .hit(hit),
        .hit_idx(hit_idx), .fetch_busy(fetch_busy)
    );

    always #5 Clk = ~Clk;

    // Glyph 1: solid rows. Glyph 2: {4'hB,row}. Glyph 3: 8'h81 | row[2:0]<<1.
    function automatic logic [7:0] font(input logic [10:0] a);
        logic [6:0] g;
        logic [3:0] r;
        g = a[10:4];
        r = a[3:0];
        case (g)
            7'd1:    font = 8'hFF;
            7'd2:    font = {4'hB, r};
            7'd3:    font = 8'h81 | {4'b0000, r[2:0], 1'b0};
            default: font = 8'h00;
        endcase
    endfunction

    always @(posedge Clk) rom_data <= font(rom_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] idx, input logic [9:0] x, input logic [9:0] y,
                      input logic [6:0] g, input logic [23:0] c, input logic s, input logic e);
        wr_en = 1'b1; wr_idx = idx; wr_x = x; wr_y = y;
        wr_glyph = g; wr_color = c; wr_scale = s; wr_enable = e;
        step();
        wr_en = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic start_line(input logic [9:0] y);
        line_start = 1'b1; line_y = y;
        step();
        line_start = 1'b0;
    endtask

    // Counts busy cycles starting from the first busy cycle; bounded.
    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (fetch_busy && cnt < 50) begin
            cnt++;
            step();
        end
    endtask

    task automatic fetch(input logic [9:0] y, input string tag);
        int c;
        start_line(y);
        wait_idle(c);
        check({tag, " busy_len"}, c, N + 1);
    endtask

    task automatic px(input string tag, input logic v, input logic [9:0] x,
                      input logic [23:0] rgb, input logic h, input logic [1:0] idx);
        pixel_valid = v; DrawX = x;
        step();
        check({tag, " rgb"}, {Red, Green, Blue}, rgb);
        check({tag, " hit"}, hit, h);
        check({tag, " idx"}, hit_idx, idx);
    endtask

    initial begin
        int         c;
        logic [7:0] pat;
        logic       b;

        // ---------------- reset ----------------
        step();
        check("rst rgb", {Red, Green, Blue}, 24'h0);
        check("rst hit", hit, 1'b0);
        check("rst idx", hit_idx, 2'd0);
        check("rst rom_addr", rom_addr, 11'd0);
        check("rst busy", fetch_busy, 1'b0);
        step();
        Reset_n = 1'b1;
        step();

        start_line(10'd0);
        check("pre-rst busy", fetch_busy, 1'b1);
        Reset_n = 1'b0;
        #1;
        check("async rst busy", fetch_busy, 1'b0);
        step();
        check("rst edge busy", fetch_busy, 1'b0);
        check("rst edge rgb", {Red, Green, Blue}, 24'h0);
        Reset_n = 1'b1;
        px("post-rst bg", 1'b1, 10'd5, 24'hFFFFFF, 1'b0, 2'd0);

        // ---------------- single sprite ----------------
        wr(2'd0, 10'd320, 10'd240, 7'd2, 24'h00FFFF, 1'b0, 1'b1);
        frame();
        start_line(10'd243);
        check("single rom_addr", rom_addr, {7'd2, 4'd3});
        wait_idle(c);
        check("single busy_len", c, N + 1);
        pat = 8'hB3;
        px("single x319", 1'b1, 10'd319, 24'hFFFFFF, 1'b0, 2'd0);
        for (int i = 0; i < 8; i++) begin
            b = pat[7 - i];
            px($sformatf("single c%0d", i), 1'b1, 10'(320 + i),
               b ? 24'h00FFFF : 24'hFFFFFF, b, 2'd0);
        end
        px("single x328", 1'b1, 10'd328, 24'hFFFFFF, 1'b0, 2'd0);
        px("single invalid", 1'b0, 10'd320, 24'h000000, 1'b0, 2'd0);

        // ---------------- priority ----------------
        wr(2'd1, 10'd320, 10'd240, 7'd1, 24'hFF0000, 1'b0, 1'b1);
        wr(2'd0, 10'd320, 10'd240, 7'd1, 24'h00FF00, 1'b0, 1'b1);
        frame();
        fetch(10'd243, "prio");
        px("prio s0", 1'b1, 10'd323, 24'h00FF00, 1'b1, 2'd0);
        wr(2'd0, 10'd320, 10'd240, 7'd1, 24'h00FF00, 1'b0, 1'b0);
        frame();
        fetch(10'd243, "prio2");
        px("prio s1", 1'b1, 10'd323, 24'hFF0000, 1'b1, 2'd1);

        // ---------------- 2x scale: row 2 = 8'h85 ----------------
        wr(2'd2, 10'd100, 10'd50, 7'd3, 24'h0000FF, 1'b1, 1'b1);
        frame();
        fetch(10'd55, "scale");
        px("scale x100", 1'b1, 10'd100, 24'h0000FF, 1'b1, 2'd2);
        px("scale x101", 1'b1, 10'd101, 24'h0000FF, 1'b1, 2'd2);
        px("scale x102", 1'b1, 10'd102, 24'hFFFFFF, 1'b0, 2'd0);
        px("scale x108", 1'b1, 10'd108, 24'hFFFFFF, 1'b0, 2'd0);
        px("scale x110", 1'b1, 10'd110, 24'h0000FF, 1'b1, 2'd2);
        px("scale x115", 1'b1, 10'd115, 24'h0000FF, 1'b1, 2'd2);
        px("scale x116", 1'b1, 10'd116, 24'hFFFFFF, 1'b0, 2'd0);

        // ---------------- double buffering ----------------
        wr(2'd2, 10'd200, 10'd50, 7'd3, 24'h0000FF, 1'b1, 1'b1);
        fetch(10'd55, "dbuf");
        px("dbuf old x100", 1'b1, 10'd100, 24'h0000FF, 1'b1, 2'd2);
        px("dbuf old x200", 1'b1, 10'd200, 24'hFFFFFF, 1'b0, 2'd0);
        frame();
        fetch(10'd55, "dbuf2");
        px("dbuf new x200", 1'b1, 10'd200, 24'h0000FF, 1'b1, 2'd2);
        px("dbuf new x100", 1'b1, 10'd100, 24'hFFFFFF, 1'b0, 2'd0);
        wr_en = 1'b1; wr_idx = 2'd2; wr_x = 10'd300; wr_y = 10'd50;
        wr_glyph = 7'd3; wr_color = 24'h0000FF; wr_scale = 1'b1; wr_enable = 1'b1;
        frame_start = 1'b1;
        step();
        wr_en = 1'b0; frame_start = 1'b0;
        fetch(10'd55, "dbuf3");
        px("dbuf sim x300", 1'b1, 10'd300, 24'h0000FF, 1'b1, 2'd2);
        px("dbuf sim x200", 1'b1, 10'd200, 24'hFFFFFF, 1'b0, 2'd0);

        // ---------------- restart during fetch ----------------
        start_line(10'd55);
        step();
        step();
        start_line(10'd55);
        wait_idle(c);
        check("restart busy_len", c, N + 1);
        px("restart x300", 1'b1, 10'd300, 24'h0000FF, 1'b1, 2'd2);

        // ---------------- right-edge clipping ----------------
        wr(2'd3, 10'd1020, 10'd50, 7'd1, 24'hFFFF00, 1'b0, 1'b1);
        frame();
        fetch(10'd55, "clip");
        px("clip x1020", 1'b1, 10'd1020, 24'hFFFF00, 1'b1, 2'd3);
        px("clip x1023", 1'b1, 10'd1023, 24'hFFFF00, 1'b1, 2'd3);
        px("clip x0", 1'b1, 10'd0, 24'hFFFFFF, 1'b0, 2'd0);
        px("clip x3", 1'b1, 10'd3, 24'hFFFFFF, 1'b0, 2'd0);
        px("blank x1021", 1'b0, 10'd1021, 24'h000000, 1'b0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
